hdmi_link_arbiter: RTL and testbench
====================================

# hdmi_link_arbiter

Packet-level arbiter that shares the single 64-bit SFP transmit stream between the HDMI video word stream and an auxiliary control/status stream, all in the `axi_clk` domain. It sits between the HDMI-to-AXI conversion path (after its clock-crossing FIFO) and the SFP transmit interface. For each granted packet it prepends a 64-bit channel header carrying a per-channel sequence number. It enforces a weighted video/aux schedule and a maximum packet length.

## Interface
Parameters:
- `VIDEO_WEIGHT`, 4: maximum consecutive video packets granted while aux is pending (≥1).
- `MAX_WORDS`, 256: maximum payload beats per packet (≥2).
- `HDR_SYNC`, 8'hA5: header sync byte.

Ports (one clock; reset is asynchronous and active-high):
- `axi_clk`  in  1  — 156.25 MHz link clock; all logic is on the rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `link_up`  in  1  — SFP link ready; new grants are made only while it is high.
- `vid_valid`, `vid_last`  in  1 — video source valid / end of packet.
- `vid_data`  in  64 — video payload.
- `vid_ready`  out  1 — video beat accepted.
- `aux_valid`, `aux_last`  in  1 — aux source valid / end of packet.
- `aux_data`  in  64 — aux payload.
- `aux_ready`  out  1 — aux beat accepted.
- `tx_valid`, `tx_last`  out  1 — SFP stream valid / end of packet.
- `tx_data`  out  64 — SFP stream data.
- `tx_ready`  in  1 — SFP sink ready.
- `busy`  out  1 — state is not IDLE.
- `err_trunc`  out  1 — one-cycle pulse when a packet is force-terminated.

## Operation
- A beat transfers when valid and ready are both high (standard handshake). Sources hold `valid` and `data` until the beat is accepted.
- The state machine has three states: IDLE, HDR, DATA.
- IDLE:
  - No output is valid; `vid_ready`=`aux_ready`=0.
  - If `link_up` is high and at least one source has `valid` high, the block registers the grant and moves to HDR.
- Grant rule:
  - Only one source valid: grant that source.
  - Both valid and `run_cnt` < `VIDEO_WEIGHT`: grant video.
  - Both valid and `run_cnt` ≥ `VIDEO_WEIGHT`: grant aux.
- `run_cnt` update (3-bit minimum width, saturating):
  - Increments on a video grant made while `aux_valid` is high.
  - Holds its value on a video grant made while aux is idle.
  - Clears to 0 on an aux grant.
- HDR:
  - `tx_valid`=1, `tx_last`=0, and both source readies are 0.
  - `tx_data` = {`HDR_SYNC`, 8-bit channel id (8'h01 video, 8'h02 aux), 16-bit `seq[ch]`, 32'h0}.
  - When `tx_ready` is high: `seq[ch]` increments (wrapping 16'hFFFF→0) and the state moves to DATA with `beat_cnt`=0.
- DATA:
  - `tx_valid`, `tx_data` and the granted source's ready pass through combinationally.
  - Granted source's ready = `tx_ready`; the other source's ready = 0.
  - `tx_last` = source `last` OR (`beat_cnt` == `MAX_WORDS`-1).
  - `beat_cnt` increments on each accepted beat.
  - When the beat carrying `tx_last` is accepted, the state returns to IDLE.
- Truncation:
  - If `tx_last` is forced (the source `last` is low on beat `MAX_WORDS`-1), `err_trunc` pulses for one cycle.
  - The source's remaining words become a new packet with a new header at the next grant.
- `link_up` is sampled only in IDLE. If `link_up` falls mid-packet, the current packet still completes.
- Stalls: `tx_ready` low holds the state, the header word and all counters unchanged.
- Reset:
  - Forces IDLE; `run_cnt`, `beat_cnt`, `seq[0]`, `seq[1]`, `err_trunc`, `tx_valid`, `tx_last`, `vid_ready`, `aux_ready` and `busy` go to 0; `tx_data` goes to 0.
  - Reset asserted mid-packet abandons the packet with no trailing `tx_last`.

## Timing
- IDLE decision: `tx_valid` (header) rises in the cycle after IDLE sees a request.
- First payload beat: can be accepted in the cycle after the header is accepted.
- Packet gap: after the last beat is accepted, one IDLE cycle follows. The earliest next header is 2 cycles after the last-beat accept.
- Link efficiency: an N-word packet occupies N+2 cycles with `tx_ready` held high.
- DATA combinational paths: `vid_valid`/`aux_valid`→`tx_valid`, `tx_ready`→`*_ready`, and source data/last→`tx_data`/`tx_last`. There are no registered outputs in DATA.
- `err_trunc` asserts in the cycle after the forced-last beat is accepted.
- `busy` is registered and is high in HDR and DATA.

## Test plan
- Video only, 3-word packet, `tx_ready`=1: `tx_data` = 64'hA501_0000_0000_0000 followed by the 3 words; `tx_last` on the 3rd word. A second packet's header carries seq 0x0001, and its header appears 2 cycles after the previous last-beat accept.
- Both sources continuously valid, `VIDEO_WEIGHT`=4: grant order is V,V,V,V,A,V,V,V,V,A. Aux headers carry 8'h02 and seq 0,1.
- Video packet of 300 words with `MAX_WORDS`=256: `tx_last` is forced on beat 256 and `err_trunc` pulses once. The remaining 44 words go out under a new header with seq+1.
- `tx_ready` toggled 1/0 every cycle during HDR and DATA: no beat is dropped or duplicated; `vid_ready` mirrors `tx_ready`; the header is held stable while stalled.
- `link_up`=0 with both sources valid: no header is issued and `busy`=0. `link_up` falling mid-packet: the packet completes, then no new grant is made.
- `rst` pulsed mid-DATA: all outputs go to 0 in the same cycle and the state is IDLE. After release, the first header carries seq 0x0000.

Source files
------------

// File: rtl/hdmi_link_arbiter_if.sv
// hdmi_link_arbiter_if: video and aux source streams plus the shared SFP transmit stream.
interface hdmi_link_arbiter_if;
  logic        vid_valid, vid_last, vid_ready;
  logic [63:0] vid_data;
  logic        aux_valid, aux_last, aux_ready;
  logic [63:0] aux_data;
  logic        tx_valid, tx_last, tx_ready;
  logic [63:0] tx_data;
  modport master (
    output vid_valid, vid_last, vid_data, aux_valid, aux_last, aux_data, tx_ready,
    input  vid_ready, aux_ready, tx_valid, tx_last, tx_data
  );
  modport slave (
    input  vid_valid, vid_last, vid_data, aux_valid, aux_last, aux_data, tx_ready,
    output vid_ready, aux_ready, tx_valid, tx_last, tx_data
  );
endinterface

// File: rtl/hdmi_link_arbiter.sv
// hdmi_link_arbiter: weighted video/aux packet arbiter onto one SFP stream, prefixing
// each packet with a sync/channel/sequence header and splitting packets longer than MAX_WORDS.
module hdmi_link_arbiter #(
  parameter int         VIDEO_WEIGHT = 4,
  parameter int         MAX_WORDS    = 256,
  parameter logic [7:0] HDR_SYNC     = 8'hA5
) (
  input  logic axi_clk,
  input  logic rst,
  input  logic link_up,
  hdmi_link_arbiter_if.slave s,
  output logic busy,
  output logic err_trunc
);
  localparam int RW = $clog2(VIDEO_WEIGHT + 1) > 3 ? $clog2(VIDEO_WEIGHT + 1) : 3;
  localparam int BW = $clog2(MAX_WORDS);
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
  state_t           state_q, state_d;
  logic             grant_q, grant_d;
  logic [RW-1:0]    run_cnt_q, run_cnt_d;
  logic [BW-1:0]    beat_cnt_q, beat_cnt_d;
  logic [1:0][15:0] seq_q, seq_d;
  logic             busy_q, busy_d, err_q, err_d;
  logic             is_hdr, is_data, src_valid, src_last, beat_max, acc, pick_aux;
  logic [63:0]      src_data;
  // grant_q selects the channel: 0 = video, 1 = aux
  assign is_hdr    = state_q == HDR;
  assign is_data   = state_q == DATA;
  assign src_valid = grant_q ? s.aux_valid : s.vid_valid;
  assign src_last  = grant_q ? s.aux_last : s.vid_last;
  assign src_data  = grant_q ? s.aux_data : s.vid_data;
  assign beat_max  = beat_cnt_q == BW'(MAX_WORDS - 1);
  assign acc       = is_data & src_valid & s.tx_ready;
  assign pick_aux  = s.aux_valid & (~s.vid_valid | run_cnt_q >= RW'(VIDEO_WEIGHT));
  assign s.tx_valid  = is_hdr | (is_data & src_valid);
  assign s.tx_last   = is_data & (src_last | beat_max);
  assign s.tx_data   = is_hdr ? {HDR_SYNC, grant_q ? 8'h02 : 8'h01, seq_q[grant_q], 32'h0}
                     : is_data ? src_data : '0;
  assign s.vid_ready = is_data & ~grant_q & s.tx_ready;
  assign s.aux_ready = is_data & grant_q & s.tx_ready;
  assign busy        = busy_q;
  assign err_trunc   = err_q;
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    run_cnt_d  = run_cnt_q;
    beat_cnt_d = beat_cnt_q;
    seq_d      = seq_q;
    err_d      = 1'b0;
    case (state_q)
      IDLE: if (link_up & (s.vid_valid | s.aux_valid)) begin
        state_d   = HDR;
        grant_d   = pick_aux;
        run_cnt_d = pick_aux ? '0 : (~s.aux_valid | &run_cnt_q) ? run_cnt_q : run_cnt_q + RW'(1);
      end
      HDR: if (s.tx_ready) begin
        state_d         = DATA;
        beat_cnt_d      = '0;
        seq_d[grant_q]  = seq_q[grant_q] + 16'd1;
      end
      default: if (acc) begin
        beat_cnt_d = beat_cnt_q + BW'(1);
        err_d      = beat_max & ~src_last;
        state_d    = s.tx_last ? IDLE : DATA;
      end
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge axi_clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      run_cnt_q  <= '0;
      beat_cnt_q <= '0;
      seq_q      <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      run_cnt_q  <= run_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      seq_q      <= seq_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: tb/tb_hdmi_link_arbiter.sv
// tb_hdmi_link_arbiter: directed scenarios for framing, weighting, truncation, stalls, link gating and reset.
module tb_hdmi_link_arbiter;
  logic clk = 1'b0, rst = 1'b1, link_up = 1'b0, busy, err_trunc;
  int total = 0, bad = 0, cyc = 0;
  int err_cnt, hold_err, mirror_err, busy_cnt;
  logic [15:0] vseq, aseq;
  logic [64:0] vq[$], aq[$], log_q[$], exp_q[$];
  int log_cyc[$];
  hdmi_link_arbiter_if bus();
  hdmi_link_arbiter dut (
    .axi_clk(clk), .rst(rst), .link_up(link_up), .s(bus), .busy(busy), .err_trunc(err_trunc)
  );
  always #5 clk = ~clk;
  function automatic logic [64:0] hdr(input logic ch, input logic [15:0] sq);
    return {1'b0, 8'hA5, ch ? 8'h02 : 8'h01, sq, 32'h0};
  endfunction
  task automatic clear_logs();
    log_q.delete(); log_cyc.delete(); exp_q.delete();
    err_cnt = 0; hold_err = 0; mirror_err = 0; busy_cnt = 0;
  endtask
  task automatic push_pkt(input logic ch, input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++)
      if (ch) aq.push_back({i == n - 1, base + 64'(i)});
      else vq.push_back({i == n - 1, base + 64'(i)});
  endtask
  task automatic expect_pkt(input logic ch, input int n, input logic [63:0] base, input logic [15:0] sq);
    exp_q.push_back(hdr(ch, sq));
    for (int i = 0; i < n; i++) exp_q.push_back({i == n - 1, base + 64'(i)});
  endtask
  // Sources present queue heads at the negedge; outputs are sampled 1 time unit later.
  task automatic run(input int n, input logic toggle);
    logic stalled = 1'b0;
    logic [64:0] held = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.tx_ready = toggle ? ~bus.tx_ready : 1'b1;
      bus.vid_valid = vq.size() > 0;
      {bus.vid_last, bus.vid_data} = vq.size() > 0 ? vq[0] : 65'd0;
      bus.aux_valid = aq.size() > 0;
      {bus.aux_last, bus.aux_data} = aq.size() > 0 ? aq[0] : 65'd0;
      #1;
      cyc++;
      if (stalled && (bus.tx_valid !== 1'b1 || {bus.tx_last, bus.tx_data} !== held)) hold_err++;
      stalled = bus.tx_valid && !bus.tx_ready;
      held = {bus.tx_last, bus.tx_data};
      if ((bus.vid_ready && !bus.tx_ready) || (bus.aux_ready && !bus.tx_ready)) mirror_err++;
      if (bus.tx_valid && bus.tx_ready) begin
        log_q.push_back({bus.tx_last, bus.tx_data});
        log_cyc.push_back(cyc);
      end
      if (bus.vid_valid && bus.vid_ready) void'(vq.pop_front());
      if (bus.aux_valid && bus.aux_ready) void'(aq.pop_front());
      err_cnt += int'(err_trunc);
      busy_cnt += int'(busy);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    vq.delete(); aq.delete();
    @(negedge clk);
    rst = 1'b0;
    vseq = 16'd0; aseq = 16'd0;
  endtask
  task automatic test_reset();
    rst = 1'b1; link_up = 1'b1; bus.tx_ready = 1'b1;
    bus.vid_valid = 1'b1; bus.vid_last = 1'b0; bus.vid_data = 64'hFFFF;
    bus.aux_valid = 1'b1; bus.aux_last = 1'b1; bus.aux_data = 64'hEEEE;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({bus.tx_valid, bus.tx_last, bus.vid_ready, bus.aux_ready, busy, err_trunc} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl got %b want 000000", {bus.tx_valid, bus.tx_last, bus.vid_ready, bus.aux_ready, busy, err_trunc});
    end
    total++;
    if (bus.tx_data !== 64'h0) begin bad++; $display("FAIL reset_data got %h want 0", bus.tx_data); end
    rst = 1'b0; bus.vid_valid = 1'b0; bus.aux_valid = 1'b0;
    vseq = 16'd0; aseq = 16'd0;
  endtask
  task automatic test_video_pkt();
    int c0;
    clear_logs();
    push_pkt(1'b0, 3, 64'h1111_0000);
    push_pkt(1'b0, 1, 64'h2222_0000);
    expect_pkt(1'b0, 3, 64'h1111_0000, vseq);
    expect_pkt(1'b0, 1, 64'h2222_0000, vseq + 16'd1);
    vseq += 16'd2;
    c0 = cyc;
    run(10, 1'b0);
    total++;
    if (log_q.size() != exp_q.size()) begin bad++; $display("FAIL vid_len got %0d want %0d", log_q.size(), exp_q.size()); end
    foreach (exp_q[k]) begin
      total++;
      if (k >= log_q.size() || log_q[k] !== exp_q[k]) begin
        bad++; $display("FAIL vid_beat%0d got %h want %h", k, k < log_q.size() ? log_q[k] : 65'h0, exp_q[k]);
      end
    end
    if (log_cyc.size() >= 5) begin
      total++;
      if (log_cyc[0] != c0 + 2) begin bad++; $display("FAIL vid_hdr_latency got %0d want %0d", log_cyc[0] - c0, 2); end
      total++;
      if (log_cyc[3] - log_cyc[0] != 3) begin bad++; $display("FAIL vid_pkt_span got %0d want 3", log_cyc[3] - log_cyc[0]); end
      total++;
      if (log_cyc[4] - log_cyc[3] != 2) begin bad++; $display("FAIL vid_gap got %0d want 2", log_cyc[4] - log_cyc[3]); end
    end
    total++;
    if (busy_cnt != 6) begin bad++; $display("FAIL vid_busy_cycles got %0d want 6", busy_cnt); end
  endtask
  task automatic test_truncation();
    clear_logs();
    push_pkt(1'b0, 300, 64'h3000_0000);
    expect_pkt(1'b0, 256, 64'h3000_0000, vseq);
    expect_pkt(1'b0, 44, 64'h3000_0000 + 64'd256, vseq + 16'd1);
    vseq += 16'd2;
    run(360, 1'b0);
    total++;
    if (log_q.size() != exp_q.size()) begin bad++; $display("FAIL trunc_len got %0d want %0d", log_q.size(), exp_q.size()); end
    foreach (exp_q[k]) begin
      total++;
      if (k >= log_q.size() || log_q[k] !== exp_q[k]) begin
        bad++; $display("FAIL trunc_beat%0d got %h want %h", k, k < log_q.size() ? log_q[k] : 65'h0, exp_q[k]);
      end
    end
    total++;
    if (err_cnt != 1) begin bad++; $display("FAIL trunc_err_pulses got %0d want 1", err_cnt); end
  endtask
  task automatic test_stall();
    clear_logs();
    push_pkt(1'b0, 3, 64'h4000_0000);
    expect_pkt(1'b0, 3, 64'h4000_0000, vseq);
    vseq += 16'd1;
    run(20, 1'b1);
    total++;
    if (log_q.size() != exp_q.size()) begin bad++; $display("FAIL stall_len got %0d want %0d", log_q.size(), exp_q.size()); end
    foreach (exp_q[k]) begin
      total++;
      if (k >= log_q.size() || log_q[k] !== exp_q[k]) begin
        bad++; $display("FAIL stall_beat%0d got %h want %h", k, k < log_q.size() ? log_q[k] : 65'h0, exp_q[k]);
      end
    end
    total++;
    if (hold_err != 0) begin bad++; $display("FAIL stall_hold got %0d want 0", hold_err); end
    total++;
    if (mirror_err != 0) begin bad++; $display("FAIL stall_ready_mirror got %0d want 0", mirror_err); end
    total++;
    if (vq.size() != 0) begin bad++; $display("FAIL stall_src_left got %0d want 0", vq.size()); end
  endtask
  task automatic test_grant_order();
    do_reset();
    clear_logs();
    for (int k = 0; k < 8; k++) push_pkt(1'b0, 2, 64'h5000_0000 + 64'(k * 16));
    for (int k = 0; k < 2; k++) push_pkt(1'b1, 1, 64'h6000_0000 + 64'(k));
    for (int k = 0; k < 4; k++) expect_pkt(1'b0, 2, 64'h5000_0000 + 64'(k * 16), 16'(k));
    expect_pkt(1'b1, 1, 64'h6000_0000, 16'd0);
    for (int k = 4; k < 8; k++) expect_pkt(1'b0, 2, 64'h5000_0000 + 64'(k * 16), 16'(k));
    expect_pkt(1'b1, 1, 64'h6000_0001, 16'd1);
    vseq = 16'd8; aseq = 16'd2;
    run(60, 1'b0);
    total++;
    if (log_q.size() != exp_q.size()) begin bad++; $display("FAIL order_len got %0d want %0d", log_q.size(), exp_q.size()); end
    foreach (exp_q[k]) begin
      total++;
      if (k >= log_q.size() || log_q[k] !== exp_q[k]) begin
        bad++; $display("FAIL order_beat%0d got %h want %h", k, k < log_q.size() ? log_q[k] : 65'h0, exp_q[k]);
      end
    end
  endtask
  task automatic test_link_down();
    clear_logs();
    link_up = 1'b0;
    push_pkt(1'b0, 4, 64'h7000_0000);
    push_pkt(1'b1, 1, 64'h8000_0000);
    run(6, 1'b0);
    total++;
    if (log_q.size() != 0) begin bad++; $display("FAIL link_down_tx got %0d want 0", log_q.size()); end
    total++;
    if (busy_cnt != 0) begin bad++; $display("FAIL link_down_busy got %0d want 0", busy_cnt); end
    expect_pkt(1'b0, 4, 64'h7000_0000, vseq);
    vseq += 16'd1;
    link_up = 1'b1;
    run(3, 1'b0);
    link_up = 1'b0;
    run(12, 1'b0);
    total++;
    if (log_q.size() != exp_q.size()) begin bad++; $display("FAIL link_len got %0d want %0d", log_q.size(), exp_q.size()); end
    foreach (exp_q[k]) begin
      total++;
      if (k >= log_q.size() || log_q[k] !== exp_q[k]) begin
        bad++; $display("FAIL link_beat%0d got %h want %h", k, k < log_q.size() ? log_q[k] : 65'h0, exp_q[k]);
      end
    end
    total++;
    if (aq.size() != 1) begin bad++; $display("FAIL link_aux_granted got %0d want 1", aq.size()); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL link_end_busy got %b want 0", busy); end
    aq.delete();
    link_up = 1'b1;
  endtask
  task automatic test_reset_mid_packet();
    clear_logs();
    push_pkt(1'b0, 5, 64'h9000_0000);
    run(4, 1'b0);
    rst = 1'b1;
    #1;
    total++;
    if ({bus.tx_valid, bus.tx_last, bus.vid_ready, bus.aux_ready, busy, err_trunc} !== 6'b0) begin
      bad++;
      $display("FAIL rst_mid_ctrl got %b want 000000", {bus.tx_valid, bus.tx_last, bus.vid_ready, bus.aux_ready, busy, err_trunc});
    end
    total++;
    if (bus.tx_data !== 64'h0) begin bad++; $display("FAIL rst_mid_data got %h want 0", bus.tx_data); end
    @(negedge clk);
    rst = 1'b0;
    vseq = 16'd0; aseq = 16'd0;
    vq.delete();
    clear_logs();
    push_pkt(1'b0, 1, 64'hA000_0000);
    expect_pkt(1'b0, 1, 64'hA000_0000, 16'd0);
    run(6, 1'b0);
    total++;
    if (log_q.size() != exp_q.size()) begin bad++; $display("FAIL rst_after_len got %0d want %0d", log_q.size(), exp_q.size()); end
    foreach (exp_q[k]) begin
      total++;
      if (k >= log_q.size() || log_q[k] !== exp_q[k]) begin
        bad++; $display("FAIL rst_after_beat%0d got %h want %h", k, k < log_q.size() ? log_q[k] : 65'h0, exp_q[k]);
      end
    end
  endtask
  initial begin
    test_reset();
    test_video_pkt();
    test_truncation();
    test_stall();
    test_grant_order();
    test_link_down();
    test_reset_mid_packet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
